// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - two-line coin sensor sync/debounce front-end with token FIFO
// Defining COIN_TOTAL_EN adds a saturating credit_total output.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_W           = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coin5_raw,
  input  logic                         coin10_raw,
  input  logic                         coin_ready,
  output logic                         coin_valid,
  output logic [1:0]                   coin,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         reject
`ifdef COIN_TOTAL_EN
  ,
  output logic [7:0]                   credit_total
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, QUAL, HELD, RELEASE} line_state_t;

  // Bit 0 is the 5 rs line, bit 1 the 10 rs line throughout.
  logic [1:0]       sync_meta;
  logic [1:0]       sync_s;
  line_state_t      state   [2];
  line_state_t      state_n [2];
  logic [CNT_W-1:0] cnt     [2];
  logic [CNT_W-1:0] cnt_n   [2];
  logic [1:0]       accept;
  logic [1:0]       ev;

  logic [1:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count;
  logic             pop, push, one_event, reject_n;
  logic [1:0]       push_data, coin_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= {coin10_raw, coin5_raw};
      sync_s    <= sync_meta;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end else begin
        state[i] <= state_n[i];
        cnt[i]   <= cnt_n[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_n[i] = state[i];
      cnt_n[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          if (sync_s[i]) begin
            state_n[i] = QUAL;
            cnt_n[i]   = CNT_ONE;
          end
        end
        QUAL: begin
          if (!sync_s[i]) begin
            state_n[i] = IDLE;
            cnt_n[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_n[i] = HELD;
            cnt_n[i]   = '0;
          end else begin
            cnt_n[i]   = cnt[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync_s[i]) begin
            state_n[i] = RELEASE;
            cnt_n[i]   = CNT_ONE;
          end
        end
        RELEASE: begin
          if (sync_s[i]) begin
            state_n[i] = HELD;
            cnt_n[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_n[i] = IDLE;
            cnt_n[i]   = '0;
          end else begin
            cnt_n[i]   = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_n[i] = IDLE;
          cnt_n[i]   = '0;
        end
      endcase
    end
  end

  // Accept fires on the sample that completes the high run; it is registered before arbitration.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 2; i++) begin
      accept[i] = (state[i] == QUAL) && sync_s[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ev <= '0;
    else      ev <= accept;
  end

  always_comb begin
    count     = wr_ptr - rd_ptr;
    pop       = coin_valid && coin_ready;
    one_event = ev[0] ^ ev[1];
    push_data = ev[1] ? 2'b10 : 2'b01;
    push      = one_event && ((count != FULL_CNT) || pop);
    reject_n  = (ev[0] && ev[1]) || (one_event && !push);
    wr_ptr_n  = wr_ptr + {{PTR_W{1'b0}}, push};
    rd_ptr_n  = rd_ptr + {{PTR_W{1'b0}}, pop};
    // Next head comes from the slot being written when the queue was otherwise drained.
    if (wr_ptr_n == rd_ptr_n)  coin_n = 2'b00;
    else if (rd_ptr_n == wr_ptr) coin_n = push_data;
    else                         coin_n = mem[rd_ptr_n[PTR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      coin_valid <= 1'b0;
      coin       <= 2'b00;
      fifo_count <= '0;
      reject     <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      coin_valid <= (wr_ptr_n != rd_ptr_n);
      coin       <= coin_n;
      fifo_count <= wr_ptr_n - rd_ptr_n;
      reject     <= reject_n;
    end
  end

`ifdef COIN_TOTAL_EN
  logic [8:0] total_sum;

  always_comb begin
    total_sum = {1'b0, credit_total} + ((push_data == 2'b10) ? 9'd10 : 9'd5);
  end

  always_ff @(posedge clk) begin
    if (!rst)      credit_total <= 8'd0;
    else if (push) credit_total <= total_sum[8] ? 8'hFF : total_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - self-checking bench for coin_acceptor
// Reference model works on sensor run lengths and a token queue; honours COIN_TOTAL_EN.
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin5_raw;
  logic       coin10_raw;
  logic       coin_ready;
  logic       coin_valid;
  logic [1:0] coin;
  logic [2:0] fifo_count;
  logic       reject;
`ifdef COIN_TOTAL_EN
  logic [7:0] credit_total;
`endif

  always #5 clk = ~clk;

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .coin_ready (coin_ready),
    .coin_valid (coin_valid),
    .coin       (coin),
    .fifo_count (fifo_count),
    .reject     (reject)
`ifdef COIN_TOTAL_EN
    ,
    .credit_total (credit_total)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [1:0] m_meta, m_s, m_ev;
  int         hi_run [2];
  int         lo_run [2];
  bit         armed  [2];
  logic [1:0] q [$];
  logic       m_reject;
  int         m_total;

  // Observations of the DUT for directed scenario checks
  logic [1:0] got [$];
  int         rej_seen;
  int         valid_cycles;
  int         first_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pop, push, both, one;
    logic [1:0] d, new_ev;
    if (!rst) begin
      m_meta = '0; m_s = '0; m_ev = '0; q.delete(); m_reject = 1'b0; m_total = 0;
      for (int i = 0; i < 2; i++) begin
        hi_run[i] = 0; lo_run[i] = 0; armed[i] = 1'b1;
      end
      return;
    end
    pop  = (q.size() > 0) && coin_ready;
    both = m_ev[0] && m_ev[1];
    one  = m_ev[0] ^ m_ev[1];
    d    = m_ev[1] ? 2'b10 : 2'b01;
    push = one && ((q.size() < DEPTH) || pop);
    m_reject = both || (one && !push);
    new_ev = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_s[i]) begin
        hi_run[i]++; lo_run[i] = 0;
        if (armed[i] && hi_run[i] == DEB) begin new_ev[i] = 1'b1; armed[i] = 1'b0; end
      end else begin
        lo_run[i]++; hi_run[i] = 0;
        if (!armed[i] && lo_run[i] == DEB) armed[i] = 1'b1;
      end
    end
    m_ev   = new_ev;
    m_s    = m_meta;
    m_meta = {coin10_raw, coin5_raw};
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(d);
      m_total = m_total + ((d == 2'b10) ? 10 : 5);
      if (m_total > 255) m_total = 255;
    end
  endtask

  task automatic step();
    logic [1:0] exp_coin;
    if (coin_valid === 1'b1 && coin_ready === 1'b1) got.push_back(coin);
    @(posedge clk);
    model_edge();
    #1;
    exp_coin = 2'b00;
    if (q.size() != 0) exp_coin = q[0];
    check("coin_valid", 32'(coin_valid), 32'(q.size() != 0));
    check("coin", 32'(coin), 32'(exp_coin));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("reject", 32'(reject), 32'(m_reject));
`ifdef COIN_TOTAL_EN
    check("credit_total", 32'(credit_total), 32'(m_total));
`endif
    if (reject === 1'b1) rej_seen++;
    if (coin_valid === 1'b1) valid_cycles++;
  endtask

  task automatic hold(input logic c5, input logic c10, input int n);
    coin5_raw  = c5;
    coin10_raw = c10;
    first_valid = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (coin_valid === 1'b1 && first_valid < 0) first_valid = k;
    end
  endtask

  task automatic clear_obs();
    got.delete(); rej_seen = 0; valid_cycles = 0;
  endtask

  initial begin
    rst = 1'b0; coin5_raw = 1'b0; coin10_raw = 1'b0; coin_ready = 1'b0;
    clear_obs();
    step(); step();
    check("rst_valid", 32'(coin_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_coin", 32'(coin), 32'd0);
    check("rst_reject", 32'(reject), 32'd0);
    rst = 1'b1;
    hold(1'b0, 1'b0, 4);

    // Single 5 rs coin with the sink always ready
    coin_ready = 1'b1;
    clear_obs();
    hold(1'b1, 1'b0, 10);
    check("single_latency", 32'(first_valid - 1), 32'(DEB + 2));
    hold(1'b0, 1'b0, 12);
    check("single_tokens", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("single_code", 32'(got[0]), 32'd1);
    check("single_valid_cycles", 32'(valid_cycles), 32'd1);
    check("single_reject", 32'(rej_seen), 32'd0);

    // Bounce on the 10 rs line before a stable insertion
    clear_obs();
    hold(1'b0, 1'b1, 1); hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 1); hold(1'b0, 1'b0, 1);
    hold(1'b0, 1'b1, 8);
    check("bounce_latency", 32'(first_valid - 1), 32'(DEB + 2));
    hold(1'b0, 1'b0, 12);
    check("bounce_tokens", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("bounce_code", 32'(got[0]), 32'd2);
    check("bounce_reject", 32'(rej_seen), 32'd0);

    // Long hold gives one token per insertion
    clear_obs();
    hold(1'b1, 1'b0, 50); hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 10); hold(1'b0, 1'b0, 12);
    check("longhold_tokens", 32'(got.size()), 32'd2);
    foreach (got[i]) check("longhold_code", 32'(got[i]), 32'd1);

    // Both sensors together are ambiguous
    clear_obs();
    hold(1'b1, 1'b1, 8); hold(1'b0, 1'b0, 12);
    check("both_reject", 32'(rej_seen), 32'd1);
    check("both_valid_cycles", 32'(valid_cycles), 32'd0);
    check("both_count", 32'(fifo_count), 32'd0);

    // Overflow with a stalled sink, then drain in order
    coin_ready = 1'b0;
    clear_obs();
    for (int c = 0; c < 5; c++) begin
      hold(c % 2 == 0, c % 2 == 1, 6);
      hold(1'b0, 1'b0, 6);
    end
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_reject", 32'(rej_seen), 32'd1);
    coin_ready = 1'b1;
    hold(1'b0, 1'b0, 8);
    check("ovf_drained", 32'(got.size()), 32'd4);
    foreach (got[i]) check("ovf_order", 32'(got[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // Reset with tokens queued
    coin_ready = 1'b0;
    clear_obs();
    for (int c = 0; c < 3; c++) begin
      hold(c != 1, c == 1, 6);
      hold(1'b0, 1'b0, 6);
    end
    check("mid_count", 32'(fifo_count), 32'd3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_valid", 32'(coin_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
`ifdef COIN_TOTAL_EN
    check("mid_rst_total", 32'(credit_total), 32'd0);
`endif
    hold(1'b0, 1'b0, 4);

    // Randomised segments against the reference model
    for (int seg = 0; seg < 80; seg++) begin
      int len;
      int sel;
      len = $urandom_range(1, 12);
      sel = $urandom_range(0, 5);
      coin5_raw  = (sel == 1) || (sel == 3);
      coin10_raw = (sel == 2) || (sel == 3);
      for (int k = 0; k < len; k++) begin
        coin_ready = 1'($urandom_range(0, 1));
        rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
        step();
      end
    end
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
